// File: rtl/sha2_const_server_pkg.sv
// Shared types and constant tables for the SHA-2 constant server.
// K is the SHA-256 round constant table; H256/H224 are the initial hash values.
package sha2_pkg;

   typedef enum logic [1:0] {
      MODE_K_SINGLE = 2'b00,
      MODE_H_SINGLE = 2'b01,
      MODE_K_STREAM = 2'b10,
      MODE_H_BURST  = 2'b11
   } req_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_STREAM_K = 2'd1,
      ST_BURST_H  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      TBL_K    = 2'd0,
      TBL_H256 = 2'd1,
      TBL_H224 = 2'd2
   } tbl_sel_t;

   localparam logic [5:0] K_LAST_IDX = 6'd63;
   localparam logic [5:0] H_LAST_IDX = 6'd7;

   localparam logic [31:0] K_TABLE [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] H256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] H224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   function automatic tbl_sel_t h_set(input logic sel224);
      return sel224 ? TBL_H224 : TBL_H256;
   endfunction

endpackage

// File: rtl/sha2_const_server_if.sv
// Request/response handshake bundle between a requester and the constant server.
interface sha2_const_server_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_mode;
   logic [5:0]  req_idx;
   logic        req_sha224;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [5:0]  rsp_idx;
   logic        rsp_last;

   modport master (
      output req_valid, req_mode, req_idx, req_sha224, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last
   );

   modport slave (
      input  req_valid, req_mode, req_idx, req_sha224, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last
   );
endinterface

// File: rtl/sha2_const_lut.sv
// Combinational lookup of one word from the K, H256 or H224 table.
module sha2_const_lut
   import sha2_pkg::*;
(
   input  tbl_sel_t    tbl_sel_i,
   input  logic [5:0]  idx_i,
   output logic [31:0] word_o
);

   always_comb begin
      word_o = '0;
      case (tbl_sel_i)
         TBL_K:    word_o = K_TABLE[idx_i];
         TBL_H256: word_o = H256[idx_i[2:0]];
         TBL_H224: word_o = H224[idx_i[2:0]];
         default:  word_o = '0;
      endcase
   end

endmodule

// File: rtl/sha2_const_server.sv
// Serves SHA-256/224 constants as single words, K streams or H bursts through a registered response.
//   state       | meaning
//   ST_IDLE     | no multi-word request pending; singles are served from here
//   ST_STREAM_K | K words cnt_q..63 still to be loaded into the response register
//   ST_BURST_H  | H words cnt_q..7 of the latched set still to be loaded
module sha2_const_server
   import sha2_pkg::*;
#(
   parameter int OUT_REG   = 1,
   parameter int EN_SHA224 = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   sha2_const_server_if.slave bus,
   output logic              busy
);

   if (OUT_REG != 1) begin : g_out_reg_chk
      $error("sha2_const_server: OUT_REG=%0d is not supported", OUT_REG);
   end

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        set224_q, set224_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_last_q, rsp_last_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [5:0]  rsp_idx_q, rsp_idx_d;

   req_mode_t   req_mode;
   logic        advance, accept, req_ready, sel224_req;
   logic        load_word, word_last;
   tbl_sel_t    lut_sel;
   logic [5:0]  lut_idx;
   logic [31:0] lut_word;

   // The response slot is free when empty or being consumed this edge.
   assign advance    = !rsp_valid_q || bus.rsp_ready;
   assign req_mode   = req_mode_t'(bus.req_mode);
   assign sel224_req = (EN_SHA224 != 0) && bus.req_sha224;
   assign req_ready  = rst_n && (state_q == ST_IDLE) && advance && !flush;
   assign accept     = bus.req_valid && req_ready;

   sha2_const_lut u_lut (
      .tbl_sel_i (lut_sel),
      .idx_i     (lut_idx),
      .word_o    (lut_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept && req_mode == MODE_K_STREAM && bus.req_idx != K_LAST_IDX) state_d = ST_STREAM_K;
               else if (accept && req_mode == MODE_H_BURST)                          state_d = ST_BURST_H;
            end
            ST_STREAM_K: if (advance && cnt_q == K_LAST_IDX) state_d = ST_IDLE;
            ST_BURST_H:  if (advance && cnt_q == H_LAST_IDX) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      lut_sel   = TBL_K;
      lut_idx   = cnt_q;
      load_word = 1'b0;
      word_last = 1'b0;
      cnt_d     = cnt_q;
      set224_d  = set224_q;
      case (state_q)
         ST_IDLE: begin
            case (req_mode)
               MODE_K_SINGLE, MODE_K_STREAM: lut_idx = bus.req_idx;
               MODE_H_SINGLE: begin
                  lut_sel = h_set(sel224_req);
                  lut_idx = {3'b000, bus.req_idx[2:0]};
               end
               MODE_H_BURST: begin
                  lut_sel = h_set(sel224_req);
                  lut_idx = '0;
               end
            endcase
            load_word = accept;
            word_last = (req_mode == MODE_K_SINGLE) || (req_mode == MODE_H_SINGLE) ||
                        (req_mode == MODE_K_STREAM && bus.req_idx == K_LAST_IDX);
            if (accept) begin
               cnt_d    = lut_idx + 6'd1;
               set224_d = sel224_req;
            end
         end
         ST_STREAM_K: begin
            load_word = advance;
            word_last = (cnt_q == K_LAST_IDX);
            if (advance) cnt_d = cnt_q + 6'd1;
         end
         ST_BURST_H: begin
            lut_sel   = h_set(set224_q);
            load_word = advance;
            word_last = (cnt_q == H_LAST_IDX);
            if (advance) cnt_d = cnt_q + 6'd1;
         end
         default: ;
      endcase
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_last_d  = rsp_last_q;
      rsp_data_d  = rsp_data_q;
      rsp_idx_d   = rsp_idx_q;
      if (flush) begin
         rsp_valid_d = 1'b0;
         rsp_last_d  = 1'b0;
      end else if (load_word) begin
         rsp_valid_d = 1'b1;
         rsp_last_d  = word_last;
         rsp_data_d  = lut_word;
         rsp_idx_d   = lut_idx;
      end else if (advance) begin
         rsp_valid_d = 1'b0;
         rsp_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         set224_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
         rsp_idx_q   <= '0;
      end else begin
         cnt_q       <= cnt_d;
         set224_q    <= set224_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         rsp_data_q  <= rsp_data_d;
         rsp_idx_q   <= rsp_idx_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_last  = rsp_last_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_idx   = rsp_idx_q;
   assign busy          = (state_q != ST_IDLE) || rsp_valid_q;

endmodule
